// File: rtl/or1k_wb_ram_slave.sv
// or1k_wb_ram_slave: Wishbone B3 RAM slave with classic/incrementing-burst support,
// programmable first-beat wait states and an address-range error response.
module or1k_wb_ram_slave #(
    parameter int          ADDR_WIDTH  = 14,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);
    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
    localparam logic [32:0] CAP = 33'd4 << ADDR_WIDTH;
    logic [31:0] mem [2**ADDR_WIDTH];
    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic ack_q, ack_d, err_q, err_d, burst_q, burst_d, ok_q, ok_d;
    logic [1:0] bte_q, bte_d;
    logic [ADDR_WIDTH-1:0] addr, addr_d, nxt, wmask;
    logic [31:0] rd_q;
    logic req, in_range, wr_en;
    assign req = wb_cyc_i & wb_stb_i;
    // below-base addresses wrap to a huge offset, so one compare covers both bounds
    assign in_range = ({1'b0, wb_adr_i} - {1'b0, BASE_ADDR}) < CAP;
    assign wmask = bte_q == 2'b01 ? ADDR_WIDTH'(3) : bte_q == 2'b10 ? ADDR_WIDTH'(7) :
                   bte_q == 2'b11 ? ADDR_WIDTH'(15) : '1;
    assign nxt = (addr & ~wmask) | ((addr + 1'b1) & wmask);
    assign wb_ack_o = ack_q & req;
    assign wb_err_o = err_q & req;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = wb_ack_o ? rd_q : '0;
    assign wr_en = wb_ack_o & wb_we_i & ~rst;
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        ack_d = 1'b0;
        err_d = 1'b0;
        addr_d = addr;
        burst_d = burst_q;
        bte_d = bte_q;
        ok_d = ok_q;
        case (state)
            IDLE: if (req && !ack_q && !err_q) begin
                addr_d = wb_adr_i[ADDR_WIDTH+1:2];
                burst_d = wb_cti_i == 3'b010;
                bte_d = wb_bte_i;
                ok_d = in_range;
                if (WAIT_STATES > 0) begin
                    state_d = WAIT;
                    cnt_d = 4'(WAIT_STATES - 1);
                end else begin
                    ack_d = in_range;
                    err_d = !in_range;
                    state_d = in_range && wb_cti_i == 3'b010 ? BURST : IDLE;
                end
            end
            WAIT: if (!wb_cyc_i) state_d = IDLE;
            else if (cnt == 4'd0) begin
                ack_d = ok_q;
                err_d = !ok_q;
                state_d = ok_q && burst_q ? BURST : IDLE;
            end else cnt_d = cnt - 4'd1;
            BURST: if (!wb_cyc_i) state_d = IDLE;
            else if (!wb_stb_i) ack_d = 1'b1;
            else begin
                addr_d = nxt;
                ack_d = wb_cti_i == 3'b010;
                state_d = wb_cti_i == 3'b010 ? BURST : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 4'd0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            burst_q <= 1'b0;
            ok_q <= 1'b0;
            bte_q <= 2'b00;
            addr <= '0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            ack_q <= ack_d;
            err_q <= err_d;
            burst_q <= burst_d;
            ok_q <= ok_d;
            bte_q <= bte_d;
            addr <= addr_d;
        end
    end
    // read port follows the next beat's address; same-word writes are forwarded
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wb_sel_i[i]) mem[addr][8*i +: 8] <= wb_dat_i[8*i +: 8];
            rd_q[8*i +: 8] <= (wr_en && wb_sel_i[i] && addr == addr_d) ? wb_dat_i[8*i +: 8] : mem[addr_d][8*i +: 8];
        end
    end
endmodule
